serial_add_sequencer: RTL

Control stage wrapped around the 4-bit `serial_adder`. It accepts operand pairs over a valid/ready handshake into a small FIFO and loads each pair into the adder. It then lets the adder run for exactly WIDTH clocks, captures the adder's `out`/`cout`, and presents the result downstream over a second valid/ready handshake. It turns the free-running bit-serial adder into a flow-controlled pipeline stage.

---
 rtl/serial_add_pkg.sv | 9 +
 rtl/operand_fifo.sv | 34 +++
 rtl/serial_adder.sv | 32 +++
 rtl/serial_add_sequencer.sv | 74 +++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and sizing helpers for the serial adder sequencer
package serial_add_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam int WIDTH_DEF = 4;
    localparam int CNT_W = $clog2(WIDTH_DEF);
    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/operand_fifo.sv
// operand_fifo: small circular FIFO of {a,b} operand pairs
module operand_fifo import serial_add_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [2*WIDTH-1:0]     din,
    output logic [2*WIDTH-1:0]     dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign dout = mem[rd_ptr];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per clock; the last bit and carry are presented combinationally
module serial_adder import serial_add_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] out,
    output logic             cout
);
    localparam int IW = cnt_bits(WIDTH);
    logic [WIDTH-1:0] a, b, s;
    logic [IW-1:0] idx;
    logic c, bit_s, bit_c;
    assign bit_s = a[idx] ^ b[idx] ^ c;
    assign bit_c = (a[idx] & b[idx]) | (c & (a[idx] ^ b[idx]));
    assign out = s | (WIDTH'(bit_s) << idx);
    assign cout = bit_c;
    always_ff @(posedge clk)
        if (reset) begin
            a   <= data_a;
            b   <= data_b;
            s   <= '0;
            c   <= 1'b0;
            idx <= '0;
        end else begin
            s[idx] <= bit_s;
            c      <= bit_c;
            idx    <= idx + 1'b1;
        end
endmodule

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: flow-controlled wrapper that feeds a bit-serial adder and returns its result
module serial_add_sequencer import serial_add_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_load,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout
);
    localparam int CW = cnt_bits(WIDTH);
    localparam int FW = $clog2(DEPTH) + 1;
    state_t state, state_d;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] head;
    logic [FW-1:0] count;
    logic full, empty, push, pop, run_done;
    assign in_ready = !reset && !full;
    assign push = in_valid && in_ready;
    assign run_done = cnt == CW'(WIDTH - 1);
    operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({in_a, in_b}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    always_comb assert (reset || count <= FW'(DEPTH));
    // The head is popped on the edge entering LOAD so the adder sees the operands during LOAD
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = empty ? IDLE : LOAD;
            LOAD:    state_d = RUN;
            RUN:     state_d = run_done ? DONE : RUN;
            DONE:    state_d = !res_ready ? DONE : (empty ? IDLE : LOAD);
            default: state_d = IDLE;
        endcase
        pop = state_d == LOAD;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_load  <= 1'b1;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= (state == RUN) ? cnt + 1'b1 : '0;
            add_load  <= state_d != RUN;
            res_valid <= state_d == DONE;
            if (pop) {add_a, add_b} <= head;
            if (state == RUN && run_done) {res_cout, res_sum} <= {add_cout, add_sum};
        end
endmodule
